// File: rtl/piso_serializer_if.sv
// Handshake bundle for the parallel-in / serial-out converter.
// The master modport is the serializer itself (it drives the serial stream);
// the slave modport is the surrounding logic that feeds words in and
// consumes bits.
interface piso_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  ser_out;
  logic                  ser_valid;
  logic                  ser_ready;
  logic                  ser_first;
  logic                  ser_last;
  logic                  busy;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output ser_out,
    output ser_valid,
    input  ser_ready,
    output ser_first,
    output ser_last,
    output busy
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  ser_out,
    input  ser_valid,
    output ser_ready,
    input  ser_first,
    input  ser_last,
    input  busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out converter with valid/ready on both sides.
// A word is captured into a shift register and emitted one bit per accepted
// cycle, with first/last frame markers. When the last bit is accepted and a
// new word is offered in the same cycle, the new word is loaded directly so
// consecutive frames stream with no idle cycle in between.
module piso_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  piso_serializer_if.master bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;

  logic                  shifting;
  logic                  is_last;
  logic                  out_bit;
  logic [DATA_WIDTH-1:0] shreg_shifted;

  // All outputs except in_ready are decoded purely from registered state.
  assign shifting      = (state_q == SHIFT);
  assign is_last       = shifting && (cnt_q == CNT_LAST);
  assign out_bit       = LSB_FIRST ? shreg_q[0] : shreg_q[DATA_WIDTH-1];
  // Move the next bit toward the output end, zero-filling behind it.
  assign shreg_shifted = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);

  assign bus.ser_valid = shifting;
  assign bus.busy      = shifting;
  assign bus.ser_out   = shifting & out_bit;
  assign bus.ser_first = shifting && (cnt_q == '0);
  assign bus.ser_last  = is_last;
  // ser_ready -> in_ready is the only input-to-output combinational path;
  // held low while reset is asserted.
  assign bus.in_ready  = rst_n && (!shifting || (is_last && bus.ser_ready));

  // State, shift register and bit counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: load on word accept, shift on bit accept, and reload
  // in place on the last bit when another word is waiting.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shreg_d = bus.in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ser_ready) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (bus.in_valid) begin
              shreg_d = bus.in_data;
              state_d = SHIFT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first
// instance share the clock, reset and upstream/downstream stimulus; a select
// chooses which instance's outputs are compared.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       ser_ready;
  logic       sel;          // 0: MSB-first instance, 1: LSB-first instance

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.DATA_WIDTH(8)) if_m ();
  piso_serializer_if #(.DATA_WIDTH(8)) if_l ();

  assign if_m.in_data   = in_data;
  assign if_m.in_valid  = in_valid;
  assign if_m.ser_ready = ser_ready;
  assign if_l.in_data   = in_data;
  assign if_l.in_valid  = in_valid;
  assign if_l.ser_ready = ser_ready;

  piso_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_m)
  );

  piso_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_l)
  );

  logic o_ready, o_out, o_valid, o_first, o_last, o_busy;
  assign o_ready = sel ? if_l.in_ready  : if_m.in_ready;
  assign o_out   = sel ? if_l.ser_out   : if_m.ser_out;
  assign o_valid = sel ? if_l.ser_valid : if_m.ser_valid;
  assign o_first = sel ? if_l.ser_first : if_m.ser_first;
  assign o_last  = sel ? if_l.ser_last  : if_m.ser_last;
  assign o_busy  = sel ? if_l.busy      : if_m.busy;

  typedef struct {
    logic       lsb;     // which instance
    logic [7:0] data;    // word to load
    logic [7:0] seq;     // expected bits in transmit order, seq[7] first
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load one word from idle with ser_ready high and check all 8 bits.
  task automatic run_frame(input logic lsb, input logic [7:0] data, input logic [7:0] seq);
    sel       = lsb;
    in_data   = data;
    in_valid  = 1'b1;
    ser_ready = 1'b1;
    #2;
    chk("load_in_ready", o_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_data  = ~data;   // must not disturb the frame in flight
    for (int i = 0; i < 8; i++) begin
      chk("frame_valid", o_valid, 1'b1);
      chk("frame_bit",   o_out,   seq[7-i]);
      chk("frame_first", o_first, (i == 0));
      chk("frame_last",  o_last,  (i == 7));
      chk("frame_busy",  o_busy,  1'b1);
      tick();
    end
    chk("frame_end_valid", o_valid, 1'b0);
    chk("frame_end_busy",  o_busy,  1'b0);
    $display("frame lsb=%0d data=%02h done (errors=%0d)", lsb, data, errors);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    logic [15:0] b2b;

    vecs[0] = '{lsb: 1'b0, data: 8'hA5, seq: 8'hA5};
    vecs[1] = '{lsb: 1'b1, data: 8'h0F, seq: 8'hF0};
    vecs[2] = '{lsb: 1'b0, data: 8'h3C, seq: 8'h3C};
    vecs[3] = '{lsb: 1'b1, data: 8'h35, seq: 8'hAC};
    vecs[4] = '{lsb: 1'b0, data: 8'h01, seq: 8'h01};

    sel       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    ser_ready = 1'b1;

    // Reset held for three cycles with a word offered.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_ready", o_ready, 1'b0);
      chk("rst_busy",  o_busy,  1'b0);
      chk("rst_out",   o_out,   1'b0);
      chk("rst_first", o_first, 1'b0);
      chk("rst_last",  o_last,  1'b0);
      $display("reset cycle %0d checked", i);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #2;
    chk("post_rst_ready", o_ready, 1'b1);
    tick();

    // Table-driven single frames.
    for (int v = 0; v < 5; v++)
      run_frame(vecs[v].lsb, vecs[v].data, vecs[v].seq);

    // Backpressure: stall two cycles while the fourth bit is presented.
    sel       = 1'b0;
    in_data   = 8'hA5;
    in_valid  = 1'b1;
    ser_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        ser_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
          #1;
          chk("bp_hold_bit",   o_out,   1'b0);
          chk("bp_hold_valid", o_valid, 1'b1);
          chk("bp_hold_first", o_first, 1'b0);
          chk("bp_hold_last",  o_last,  1'b0);
          chk("bp_hold_ready", o_ready, 1'b0);
          tick();
        end
        ser_ready = 1'b1;
      end
      chk("bp_bit",   o_out,   i inside {0, 2, 5, 7});
      chk("bp_first", o_first, (i == 0));
      chk("bp_last",  o_last,  (i == 7));
      tick();
    end
    chk("bp_end_valid", o_valid, 1'b0);
    $display("backpressure sequence done (errors=%0d)", errors);

    // Back-to-back frames 0x3C then 0xC3.
    b2b      = 16'h3CC3;
    in_data  = 8'h3C;
    in_valid = 1'b1;
    #2;
    chk("b2b_load_ready", o_ready, 1'b1);
    tick();
    in_data = 8'hC3;
    for (int j = 0; j < 16; j++) begin
      if (j >= 8) in_valid = 1'b0;
      #1;
      chk("b2b_valid", o_valid, 1'b1);
      chk("b2b_bit",   o_out,   b2b[15-j]);
      chk("b2b_first", o_first, (j == 0 || j == 8));
      chk("b2b_last",  o_last,  (j == 7 || j == 15));
      if (j < 15) chk("b2b_in_ready", o_ready, (j == 7));
      tick();
    end
    chk("b2b_end_valid", o_valid, 1'b0);
    $display("back-to-back sequence done (errors=%0d)", errors);

    // Reset in the middle of a frame of 0xFF.
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mid_bit", o_out, 1'b1);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", o_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", o_valid, 1'b0);
    chk("mid_rst_last",  o_last,  1'b0);
    chk("mid_rst_busy",  o_busy,  1'b0);
    $display("mid-frame reset checked (errors=%0d)", errors);
    run_frame(1'b0, 8'h81, 8'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
